bcd_ascii_serializer: RTL

BCD_ASCII_SERIALIZER -- requirements
Module: bcd_ascii_serializer

---
 rtl/bcd_ascii_serializer.sv | 127 ++++++++++++
 1 files changed

// File: rtl/bcd_ascii_serializer.sv
// ============================================================================
// Module   : bcd_ascii_serializer
// Purpose  : Serializes a 5-digit packed BCD value as ASCII characters over a
//            valid/ready handshake, most significant digit first.
// Option   : LEADING_ZERO_BLANK_EN - replaces leading zero digits with PAD_CHAR
//            (the least significant digit is always shown numerically).
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module bcd_ascii_serializer #(
  parameter logic [7:0] PAD_CHAR = 8'h20
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic [19:0] bcd_in,
  input  logic        start,
  input  logic        char_ready,
  output logic [7:0]  char_data,
  output logic        char_valid,
  output logic        busy,
  output logic        done
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    SEND = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t      state_q, state_d;
  logic [2:0]  index_q, index_d;
  logic [19:0] shadow_q, shadow_d;

  logic [3:0]  w_nibble;
  logic        w_blank;
  logic [7:0]  w_ascii;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q  <= IDLE;
      index_q  <= 3'd0;
      shadow_q <= 20'h0;
    end else begin
      state_q  <= state_d;
      index_q  <= index_d;
      shadow_q <= shadow_d;
    end
  end

  always_comb begin
    state_d  = state_q;
    index_d  = index_q;
    shadow_d = shadow_q;
    case (state_q)
      IDLE: begin
        if (start) begin
          shadow_d = bcd_in;
          index_d  = 3'd0;
          state_d  = SEND;
        end
      end
      SEND: begin
        if (char_ready) begin
          if (index_q == 3'd4) begin
            index_d = 3'd0;
            state_d = DONE;
          end else begin
            index_d = index_q + 3'd1;
          end
        end
      end
      DONE: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  always_comb begin
    w_nibble = 4'h0;
    case (index_q)
      3'd0:    w_nibble = shadow_q[19:16];
      3'd1:    w_nibble = shadow_q[15:12];
      3'd2:    w_nibble = shadow_q[11:8];
      3'd3:    w_nibble = shadow_q[7:4];
      3'd4:    w_nibble = shadow_q[3:0];
      default: w_nibble = 4'h0;
    endcase
  end

`ifdef LEADING_ZERO_BLANK_EN
  // A digit is blanked only while it and every more significant digit are zero.
  always_comb begin
    w_blank = 1'b0;
    case (index_q)
      3'd0:    w_blank = (shadow_q[19:16] == 4'h0);
      3'd1:    w_blank = (shadow_q[19:12] == 8'h0);
      3'd2:    w_blank = (shadow_q[19:8]  == 12'h0);
      3'd3:    w_blank = (shadow_q[19:4]  == 16'h0);
      default: w_blank = 1'b0;
    endcase
  end
`else
  assign w_blank = 1'b0;
`endif

  always_comb begin
    if (w_blank) begin
      w_ascii = PAD_CHAR;
    end else if (w_nibble > 4'd9) begin
      w_ascii = 8'h3F;
    end else begin
      w_ascii = 8'h30 + {4'h0, w_nibble};
    end
  end

  assign char_valid = (state_q == SEND);
  assign char_data  = char_valid ? w_ascii : 8'h00;
  assign busy       = (state_q != IDLE);
  assign done       = (state_q == DONE);

endmodule

`default_nettype wire
